match_collector: RTL and testbench
==================================

Name: match_collector

Overview:
- Downstream consumer of the pattern-search engine.
- Sequences the engine (reset pulse, then hold activate) and captures every new match address it reports on its found output.
- Buffers match addresses in a small FIFO for readout by the display/UART stage, with a match count, overflow flag and completion flag.

Parameters:
- DEPTH, 16, result FIFO entries (power of two).
- AW, 15, match address width (matches the engine's found width).
- CW, 8, match counter width.

Ports:
- CLK100MHZ  in  1  system clock; all logic on rising edge.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a new search run.
- search_done  in  1  engine done flag; level, held high by the engine.
- search_found  in  AW  engine match address; reads 15'h00FF after engine reset.
- search_reset  out  1  drives the engine's reset.
- search_activate  out  1  drives the engine's activate.
- rd_valid  out  1  FIFO holds at least one entry.
- rd_addr  out  AW  FIFO head entry; valid only while rd_valid=1.
- rd_ready  in  1  consumer pops the head when rd_valid&&rd_ready.
- match_count  out  CW  number of matches captured this run; saturating.
- overflow  out  1  sticky; set when a match was dropped because the FIFO was full.
- busy  out  1  high in CLEAR and RUN.
- complete  out  1  high in DONE.

Behaviour:
- Reset (CPU_RESETN=0, async):
  - State=IDLE; search_reset=1; search_activate=0.
  - FIFO empty (rd_valid=0, rd_addr=0); match_count=0; overflow=0; busy=0; complete=0; found_q=15'h00FF.
- States: IDLE, CLEAR, RUN, DONE (one-hot encoded).
- IDLE:
  - search_reset=1, search_activate=0.
  - start=1 -> CLEAR; on that edge: flush FIFO, match_count=0, overflow=0, found_q=15'h00FF.
- CLEAR:
  - Exactly 2 cycles with search_reset=1, search_activate=0; then -> RUN.
- RUN:
  - search_reset=0, search_activate=1.
  - Capture when search_found != found_q. On that edge: found_q<=search_found, push search_found, and increment match_count (saturates at 2^CW-1).
  - Capture latency: search_found changes in cycle N -> entry written at end of N -> rd_valid=1 from cycle N+1 (if FIFO was empty).
  - search_done=1 -> DONE. The capture check is still evaluated in that same cycle.
- DONE:
  - search_activate=0, search_reset=0 (engine holds its result), complete=1.
  - start=1 -> CLEAR, with the same clearing as from IDLE. Unread FIFO contents are discarded.
- start while in CLEAR or RUN: ignored.
- FIFO rules:
  - Circular buffer with read/write pointers of log2(DEPTH)+1 bits. Full when the pointer MSBs differ and the LSBs are equal.
  - Push while full and no pop in the same cycle: entry dropped, overflow<=1. match_count still increments.
  - Simultaneous push and pop while full: both accepted, no drop, occupancy unchanged.
  - Pop while empty: ignored.
  - rd_addr is registered: it updates on the edge of a pop or of a push into an empty FIFO. It never changes while rd_valid=1 and rd_ready=0.
  - Readout is allowed in every state. The FIFO is only cleared by reset or a start accepted from IDLE/DONE.
- Accepted limitation: a genuine match at address 15'h00FF as the first match of a run is indistinguishable from the post-reset value and is not captured.
- Async reset mid-run: everything returns to reset values immediately. search_reset=1 asserts asynchronously, so the engine is also reset.
- Widths: match_count saturates, never wraps. search_found is stored unmodified, with no arithmetic on it.

Test Plan:
- Reset then start; engine model reports found 0x0003 at cycle 10, 0x0010 at cycle 30, done at cycle 50 -> rd_addr sequence 0x0003, 0x0010; match_count=2; complete=1; search_reset high for exactly 2 cycles after start; search_activate high from cycle 3 until DONE.
- 20 distinct found values, rd_ready=0 throughout -> first 16 stored in order, overflow=1, match_count=20; after draining, rd_valid=0.
- FIFO full, push and pop in the same cycle (rd_ready=1, new found) -> no drop, overflow stays 0, occupancy stays 16, new value read out last.
- start pulsed during RUN -> ignored, no extra search_reset pulse; start pulsed in DONE with 3 unread entries -> FIFO flushed, match_count=0, new CLEAR/RUN sequence begins.
- CPU_RESETN low for 1 cycle mid-RUN with 5 entries buffered -> immediate rd_valid=0, match_count=0, search_reset=1, state IDLE; no activity until next start.
- search_done and a new found value in the same RUN cycle -> value captured, match_count incremented, transition to DONE.

Source files
------------

// File: rtl/match_collector_if.sv
// match_collector_if: engine control and result-readout signals of the match collector
interface match_collector_if #(
    parameter int AW = 15,
    parameter int CW = 8
);
    logic          start;
    logic          search_done;
    logic [AW-1:0] search_found;
    logic          search_reset;
    logic          search_activate;
    logic          rd_valid;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic [CW-1:0] match_count;
    logic          overflow;
    logic          busy;
    logic          complete;

    modport master (
        output start, search_done, search_found, rd_ready,
        input  search_reset, search_activate, rd_valid, rd_addr, match_count, overflow, busy, complete
    );

    modport slave (
        input  start, search_done, search_found, rd_ready,
        output search_reset, search_activate, rd_valid, rd_addr, match_count, overflow, busy, complete
    );
endinterface

// File: rtl/match_collector.sv
// match_collector: sequences the search engine and buffers each new match address in a FIFO
module match_collector #(
    parameter int DEPTH = 16,
    parameter int AW    = 15,
    parameter int CW    = 8
) (
    input  logic           CLK100MHZ,
    input  logic           CPU_RESETN,
    match_collector_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [AW-1:0] FOUND_RST = AW'(15'h00FF);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_CLEAR = 4'b0010,
        S_RUN   = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    state_t        r_state, w_next;
    logic          r_clr;
    logic [AW-1:0] r_found_q;
    logic [AW-1:0] r_rd_addr;
    logic [AW-1:0] r_mem [DEPTH];
    logic [PW:0]   r_wptr, r_rptr, w_rnext;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          w_start_ok, w_capture, w_empty, w_full, w_pop, w_push, w_drop;
    logic          w_search_reset, w_search_activate;

    assign w_start_ok = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_capture  = (r_state == S_RUN) && (bus.search_found != r_found_q);
    assign w_empty    = r_wptr == r_rptr;
    assign w_full     = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_pop      = bus.rd_ready && !w_empty;
    assign w_push     = w_capture && (!w_full || w_pop);
    assign w_drop     = w_capture && w_full && !w_pop;
    assign w_rnext    = r_rptr + (PW+1)'(w_pop);

    // Next state and engine controls; the engine stays in reset in IDLE and CLEAR
    always_comb begin
        w_next            = r_state;
        w_search_reset    = 1'b0;
        w_search_activate = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_search_reset = 1'b1;
                if (bus.start) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                w_search_reset = 1'b1;
                if (r_clr) w_next = S_RUN;
            end
            S_RUN: begin
                w_search_activate = 1'b1;
                if (bus.search_done) w_next = S_DONE;
            end
            S_DONE: begin
                if (bus.start) w_next = S_CLEAR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register; r_clr marks the second CLEAR cycle
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state <= S_IDLE;
            r_clr   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_clr   <= (r_state == S_CLEAR) && !r_clr;
        end
    end

    // FIFO pointers, registered head, match counter and sticky overflow; a new run flushes all
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rd_addr  <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_found_q  <= FOUND_RST;
        end else if (w_start_ok) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rd_addr  <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_found_q  <= FOUND_RST;
        end else begin
            if (w_capture) begin
                r_found_q <= bus.search_found;
                if (r_count != '1) r_count <= r_count + CW'(1);
            end
            if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
            if (w_pop) r_rptr <= w_rnext;
            if (w_drop) r_overflow <= 1'b1;
            if (w_pop || (w_push && w_empty))
                r_rd_addr <= (w_push && r_wptr == w_rnext) ? bus.search_found : r_mem[w_rnext[PW-1:0]];
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge CLK100MHZ) begin
        if (w_push) r_mem[r_wptr[PW-1:0]] <= bus.search_found;
    end

    assign bus.search_reset    = w_search_reset;
    assign bus.search_activate = w_search_activate;
    assign bus.rd_valid        = !w_empty;
    assign bus.rd_addr         = r_rd_addr;
    assign bus.match_count     = r_count;
    assign bus.overflow        = r_overflow;
    assign bus.busy            = (r_state == S_CLEAR) || (r_state == S_RUN);
    assign bus.complete        = r_state == S_DONE;
endmodule

// File: tb/tb_match_collector.sv
// tb_match_collector: directed checks of engine sequencing, capture, FIFO and flags
module tb_match_collector;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_err = 0;
    int n_chk = 0;

    match_collector_if #(.AW(15), .CW(8)) bus();

    match_collector #(.DEPTH(16), .AW(15), .CW(8)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_start();
        bus.start        = 1'b1;
        bus.search_done  = 1'b0;
        bus.search_found = 15'h00FF;
        step();
        bus.start = 1'b0;
        check("clr1 reset", bus.search_reset, 1);
        check("clr1 act", bus.search_activate, 0);
        check("clr1 busy", bus.busy, 1);
        check("clr1 valid", bus.rd_valid, 0);
        check("clr1 count", bus.match_count, 0);
        check("clr1 ovf", bus.overflow, 0);
        step();
        check("clr2 reset", bus.search_reset, 1);
        step();
        check("run reset", bus.search_reset, 0);
        check("run act", bus.search_activate, 1);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.search_done  = 1'b0;
        bus.search_found = 15'h00FF;
        bus.rd_ready     = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst valid", bus.rd_valid, 0);
        check("rst addr", bus.rd_addr, 0);
        check("rst count", bus.match_count, 0);
        check("rst ovf", bus.overflow, 0);
        check("rst busy", bus.busy, 0);
        check("rst complete", bus.complete, 0);
        check("rst sreset", bus.search_reset, 1);
        check("rst act", bus.search_activate, 0);
        step(2);
        rst_n = 1'b1;
        step();
        check("idle sreset", bus.search_reset, 1);

        // basic run: matches at cycles 10 and 30, done at 50
        run_start();
        step(7);
        check("t1 pre valid", bus.rd_valid, 0);
        bus.search_found = 15'h0003;
        step();
        check("t1 valid", bus.rd_valid, 1);
        check("t1 addr0", bus.rd_addr, 15'h0003);
        check("t1 count1", bus.match_count, 1);
        step(19);
        bus.search_found = 15'h0010;
        step();
        check("t1 count2", bus.match_count, 2);
        check("t1 head held", bus.rd_addr, 15'h0003);
        step(19);
        bus.search_done = 1'b1;
        step();
        check("t1 complete", bus.complete, 1);
        check("t1 done act", bus.search_activate, 0);
        check("t1 done sreset", bus.search_reset, 0);
        check("t1 done busy", bus.busy, 0);
        bus.rd_ready = 1'b1;
        step();
        check("t1 addr1", bus.rd_addr, 15'h0010);
        check("t1 valid1", bus.rd_valid, 1);
        step();
        check("t1 drained", bus.rd_valid, 0);
        bus.rd_ready = 1'b0;

        // overflow: 20 matches, no readout
        run_start();
        for (int i = 0; i < 20; i++) begin
            bus.search_found = 15'(32'h100 + i);
            step();
        end
        check("t2 count", bus.match_count, 20);
        check("t2 ovf", bus.overflow, 1);
        check("t2 valid", bus.rd_valid, 1);
        for (int i = 0; i < 16; i++) begin
            check("t2 order", bus.rd_addr, 32'h100 + i);
            bus.rd_ready = 1'b1;
            step();
        end
        check("t2 drained", bus.rd_valid, 0);
        bus.rd_ready = 1'b0;
        bus.search_done = 1'b1;
        step();

        // full FIFO with simultaneous push and pop
        run_start();
        for (int i = 0; i < 16; i++) begin
            bus.search_found = 15'(32'h200 + i);
            step();
        end
        check("t3 ovf full", bus.overflow, 0);
        check("t3 count16", bus.match_count, 16);
        bus.search_found = 15'h02AA;
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
        check("t3 ovf pp", bus.overflow, 0);
        check("t3 count17", bus.match_count, 17);
        for (int i = 1; i < 16; i++) begin
            check("t3 order", bus.rd_addr, 32'h200 + i);
            bus.rd_ready = 1'b1;
            step();
        end
        check("t3 last", bus.rd_addr, 15'h02AA);
        check("t3 last valid", bus.rd_valid, 1);
        step();
        check("t3 drained", bus.rd_valid, 0);
        bus.rd_ready = 1'b0;

        // start ignored in RUN, honoured in DONE with unread entries
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("t4 no sreset", bus.search_reset, 0);
        check("t4 still act", bus.search_activate, 1);
        check("t4 busy", bus.busy, 1);
        step();
        check("t4 no sreset2", bus.search_reset, 0);
        for (int i = 1; i <= 3; i++) begin
            bus.search_found = 15'(32'h300 + i);
            step();
        end
        bus.search_done = 1'b1;
        step();
        check("t4 complete", bus.complete, 1);
        check("t4 unread", bus.rd_valid, 1);
        check("t4 count", bus.match_count, 20);
        bus.start = 1'b1;
        bus.search_done = 1'b0;
        bus.search_found = 15'h00FF;
        step();
        bus.start = 1'b0;
        check("t4 flushed", bus.rd_valid, 0);
        check("t4 count0", bus.match_count, 0);
        check("t4 clr sreset", bus.search_reset, 1);
        check("t4 clr busy", bus.busy, 1);
        step(2);
        check("t4 rerun act", bus.search_activate, 1);

        // async reset mid-run with 5 buffered entries
        for (int i = 1; i <= 5; i++) begin
            bus.search_found = 15'(32'h400 + i);
            step();
        end
        check("t5 count5", bus.match_count, 5);
        check("t5 valid", bus.rd_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5 async valid", bus.rd_valid, 0);
        check("t5 async count", bus.match_count, 0);
        check("t5 async sreset", bus.search_reset, 1);
        check("t5 async act", bus.search_activate, 0);
        check("t5 async busy", bus.busy, 0);
        step();
        rst_n = 1'b1;
        for (int i = 6; i <= 8; i++) begin
            bus.search_found = 15'(32'h400 + i);
            step();
        end
        check("t5 idle valid", bus.rd_valid, 0);
        check("t5 idle count", bus.match_count, 0);
        check("t5 idle sreset", bus.search_reset, 1);
        check("t5 idle busy", bus.busy, 0);

        // done and new match in the same cycle
        run_start();
        bus.search_found = 15'h0555;
        bus.search_done = 1'b1;
        step();
        check("t6 count", bus.match_count, 1);
        check("t6 valid", bus.rd_valid, 1);
        check("t6 addr", bus.rd_addr, 15'h0555);
        check("t6 complete", bus.complete, 1);

        // counter saturation
        run_start();
        for (int i = 0; i < 260; i++) begin
            bus.search_found = 15'(32'h600 + i);
            step();
        end
        check("t7 saturate", bus.match_count, 8'hFF);
        check("t7 ovf", bus.overflow, 1);
        bus.search_done = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
